sdiv_arbiter: RTL

Round-robin arbiter and sequencer that shares one serial 8-bit/4-bit divider between two requesters. It captures a requester's operands and issues a one-cycle Start to the divider. It then follows the divider's Ready handshake and returns quotient and remainder to the winning requester with a one-cycle done pulse. It sits between client logic and the serial divider core; both share the same clock and reset.

---
 rtl/sdiv_arbiter.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sdiv_arbiter.sv
// Round-robin front end sharing one serial 8/4-bit divider between two client ports.
// Optional macro SDIV_ERRCHK_EN: reject divide-by-zero / quotient overflow without using the divider.
module sdiv_arbiter #(
   parameter int TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] word1_0,
   input  logic [7:0] word1_1,
   input  logic [3:0] word2_0,
   input  logic [3:0] word2_1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] quotient0,
   output logic [3:0] quotient1,
   output logic [3:0] reminder0,
   output logic [3:0] reminder1,
   output logic       err0,
   output logic       err1,
   output logic [7:0] div_word1,
   output logic [3:0] div_word2,
   output logic       div_start,
   input  logic [3:0] div_quotient,
   input  logic [3:0] div_reminder,
   input  logic       div_ready,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } state_t;

   // Each phase counter starts at 1 on the cycle that opens the phase, so abort fires
   // when the next count would reach TIMEOUT.
   localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       win_q, win_d;
   logic       last_q, last_d;
   logic       chk_err_q, chk_err_d;
   logic [4:0] cnt_q, cnt_d;
   logic [7:0] w1_q, w1_d;
   logic [3:0] w2_q, w2_d;
   logic [3:0] quo0_q, quo0_d, quo1_q, quo1_d;
   logic [3:0] rem0_q, rem0_d, rem1_q, rem1_d;
   logic       err0_q, err0_d, err1_q, err1_d;

   logic       sel1_s;
   logic [7:0] cand_w1_s;
   logic [3:0] cand_w2_s;
   logic       pre_err_s;
   logic       to_s;
   logic       wr_s;
   logic [3:0] wr_quo_s, wr_rem_s;
   logic       wr_err_s;

   // Winner selection and operand pre-check for a grant in IDLE
   always_comb begin
      if (req0 && req1) begin
         sel1_s = ~last_q;
      end else begin
         sel1_s = req1;
      end
      cand_w1_s = sel1_s ? word1_1 : word1_0;
      cand_w2_s = sel1_s ? word2_1 : word2_0;
      pre_err_s = 1'b0;
`ifdef SDIV_ERRCHK_EN
      pre_err_s = (cand_w2_s == 4'd0) || (cand_w1_s[7:4] >= cand_w2_s);
`endif
   end

   assign to_s = (cnt_q == TO_LAST);

   // Sequencer next-state, grant/start strobes and result write request
   always_comb begin
      state_d   = state_q;
      win_d     = win_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      w1_d      = w1_q;
      w2_d      = w2_q;
      chk_err_d = chk_err_q;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      div_start = 1'b0;
      wr_s      = 1'b0;
      wr_quo_s  = 4'h0;
      wr_rem_s  = 4'h0;
      wr_err_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt0      = ~sel1_s;
               gnt1      = sel1_s;
               win_d     = sel1_s;
               w1_d      = cand_w1_s;
               w2_d      = cand_w2_s;
               chk_err_d = pre_err_s;
               cnt_d     = 5'd1;
               state_d   = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            // A rejected operand pair passes through ISSUE without touching the divider
            if (chk_err_q) begin
               wr_s     = 1'b1;
               wr_quo_s = 4'hF;
               wr_rem_s = w1_q[3:0];
               wr_err_s = 1'b1;
               state_d  = RESP;
            end else if (div_ready) begin
               div_start = 1'b1;
               cnt_d     = 5'd1;
               state_d   = WAIT_BUSY;
            end else if (to_s) begin
               wr_s     = 1'b1;
               wr_quo_s = 4'hF;
               wr_rem_s = 4'hF;
               wr_err_s = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         WAIT_BUSY: begin
            if (!div_ready) begin
               cnt_d   = 5'd1;
               state_d = WAIT_DONE;
            end else if (to_s) begin
               wr_s     = 1'b1;
               wr_quo_s = 4'hF;
               wr_rem_s = 4'hF;
               wr_err_s = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         WAIT_DONE: begin
            if (div_ready) begin
               wr_s     = 1'b1;
               wr_quo_s = div_quotient;
               wr_rem_s = div_reminder;
               wr_err_s = 1'b0;
               state_d  = RESP;
            end else if (to_s) begin
               wr_s     = 1'b1;
               wr_quo_s = 4'hF;
               wr_rem_s = 4'hF;
               wr_err_s = 1'b1;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         RESP: begin
            last_d    = win_q;
            chk_err_d = 1'b0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Per-port result registers; only the current winner is ever written
   always_comb begin
      if (wr_s && !win_q) begin
         quo0_d = wr_quo_s;
         rem0_d = wr_rem_s;
         err0_d = wr_err_s;
      end else begin
         quo0_d = quo0_q;
         rem0_d = rem0_q;
         err0_d = err0_q;
      end
      if (wr_s && win_q) begin
         quo1_d = wr_quo_s;
         rem1_d = wr_rem_s;
         err1_d = wr_err_s;
      end else begin
         quo1_d = quo1_q;
         rem1_d = rem1_q;
         err1_d = err1_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         win_q     <= 1'b0;
         last_q    <= 1'b1;
         chk_err_q <= 1'b0;
         cnt_q     <= 5'd0;
         w1_q      <= 8'h00;
         w2_q      <= 4'h0;
         quo0_q    <= 4'h0;
         rem0_q    <= 4'h0;
         err0_q    <= 1'b0;
         quo1_q    <= 4'h0;
         rem1_q    <= 4'h0;
         err1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         last_q    <= last_d;
         chk_err_q <= chk_err_d;
         cnt_q     <= cnt_d;
         w1_q      <= w1_d;
         w2_q      <= w2_d;
         quo0_q    <= quo0_d;
         rem0_q    <= rem0_d;
         err0_q    <= err0_d;
         quo1_q    <= quo1_d;
         rem1_q    <= rem1_d;
         err1_q    <= err1_d;
      end
   end

   assign done0     = (state_q == RESP) && !win_q;
   assign done1     = (state_q == RESP) && win_q;
   assign busy      = (state_q != IDLE);
   assign div_word1 = w1_q;
   assign div_word2 = w2_q;
   assign quotient0 = quo0_q;
   assign reminder0 = rem0_q;
   assign err0      = err0_q;
   assign quotient1 = quo1_q;
   assign reminder1 = rem1_q;
   assign err1      = err1_q;

endmodule
